// File: rtl/pipeline_wb_forward_if.sv
// Write-back/forwarding bus between EX/MEM result sources, ID lookup and the register file.
interface pipeline_wb_forward_if #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic [REG_W-1:0]  ex_reg;
  logic [DATA_W-1:0] ex_data;
  logic              mem_valid;
  logic [REG_W-1:0]  mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic              write_en;
  logic [REG_W-1:0]  reg_write;
  logic [DATA_W-1:0] data_write;
  logic              stall;

  modport master (
    output ex_valid, ex_reg, ex_data, mem_valid, mem_reg, mem_data, rs1, rs2,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, write_en, reg_write, data_write, stall
  );

  modport slave (
    input  ex_valid, ex_reg, ex_data, mem_valid, mem_reg, mem_data, rs1, rs2,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, write_en, reg_write, data_write, stall
  );
endinterface

// File: rtl/pipeline_wb_forward.sv
// Pending register-write FIFO with youngest-first forwarding lookup for ID.
// Optional WB_PERF_COUNT_EN adds saturating perf_writes/perf_stalls counters.
module pipeline_wb_forward #(
  parameter int DEPTH  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_wb_forward_if.slave bus
`ifdef WB_PERF_COUNT_EN
  ,
  output logic [31:0]          perf_writes,
  output logic [31:0]          perf_stalls
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(DEPTH - 1);

  logic [REG_W-1:0]  q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic              write_en;
  logic [REG_W-1:0]  reg_write;
  logic [DATA_W-1:0] data_write;
  logic              stall;
  logic              mem_acc, ex_acc, pop;
  logic [1:0]        pushes;

  logic              f1_hit, f2_hit;
  logic [DATA_W-1:0] f1_data, f2_data;

  // Occupancy alone tells empty from full; a worst-case cycle pushes two.
  assign stall   = (count >= STALL_AT);
  assign mem_acc = !stall && bus.mem_valid && (bus.mem_reg != '0);
  assign ex_acc  = !stall && bus.ex_valid  && (bus.ex_reg  != '0);
  assign pop     = (count != '0);
  assign pushes  = {1'b0, mem_acc} + {1'b0, ex_acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      write_en   <= 1'b0;
      reg_write  <= '0;
      data_write <= '0;
    end else begin
      if (pop) begin
        write_en   <= 1'b1;
        reg_write  <= q_reg[head];
        data_write <= q_data[head];
        head       <= head + 1'b1;
      end else begin
        write_en   <= 1'b0;
      end
      tail  <= tail + PTR_W'(pushes);
      count <= count + CNT_W'(pushes) - CNT_W'(pop);
    end
  end

  // MEM is the older instruction, so it takes the first free slot.
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      q_reg[tail]  <= bus.mem_reg;
      q_data[tail] <= bus.mem_data;
    end
    if (ex_acc) begin
      q_reg[tail + PTR_W'(mem_acc)]  <= bus.ex_reg;
      q_data[tail + PTR_W'(mem_acc)] <= bus.ex_data;
    end
  end

  // Sources are scanned lowest priority first so each later match overrides.
  always_comb begin
    f1_hit  = 1'b0;
    f1_data = '0;
    f2_hit  = 1'b0;
    f2_data = '0;
    if (write_en && reg_write == bus.rs1) begin f1_hit = 1'b1; f1_data = data_write; end
    if (write_en && reg_write == bus.rs2) begin f2_hit = 1'b1; f2_data = data_write; end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && q_reg[head + PTR_W'(i)] == bus.rs1) begin
        f1_hit  = 1'b1;
        f1_data = q_data[head + PTR_W'(i)];
      end
      if (CNT_W'(i) < count && q_reg[head + PTR_W'(i)] == bus.rs2) begin
        f2_hit  = 1'b1;
        f2_data = q_data[head + PTR_W'(i)];
      end
    end
    if (bus.mem_valid && bus.mem_reg == bus.rs1) begin f1_hit = 1'b1; f1_data = bus.mem_data; end
    if (bus.mem_valid && bus.mem_reg == bus.rs2) begin f2_hit = 1'b1; f2_data = bus.mem_data; end
    if (bus.ex_valid && bus.ex_reg == bus.rs1) begin f1_hit = 1'b1; f1_data = bus.ex_data; end
    if (bus.ex_valid && bus.ex_reg == bus.rs2) begin f2_hit = 1'b1; f2_data = bus.ex_data; end
    if (bus.rs1 == '0) begin f1_hit = 1'b0; f1_data = '0; end
    if (bus.rs2 == '0) begin f2_hit = 1'b0; f2_data = '0; end
  end

  assign bus.fwd1_hit   = f1_hit;
  assign bus.fwd1_data  = f1_data;
  assign bus.fwd2_hit   = f2_hit;
  assign bus.fwd2_data  = f2_data;
  assign bus.write_en   = write_en;
  assign bus.reg_write  = reg_write;
  assign bus.data_write = data_write;
  assign bus.stall      = stall;

`ifdef WB_PERF_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (write_en && perf_writes != '1) perf_writes <= perf_writes + 1'b1;
      if (stall && perf_stalls != '1)    perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_wb_forward.sv
// Directed bench for pipeline_wb_forward: scoreboard of expected register writes plus lookup/stall checks.
module tb_pipeline_wb_forward;
  localparam int DEPTH  = 4;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_wb_forward_if #(.REG_W(REG_W), .DATA_W(DATA_W)) bus ();

`ifdef WB_PERF_COUNT_EN
  logic [31:0] perf_writes, perf_stalls;
`endif

  pipeline_wb_forward #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef WB_PERF_COUNT_EN
    ,
    .perf_writes (perf_writes),
    .perf_stalls (perf_stalls)
`endif
  );

  int total = 0;
  int bad   = 0;
  int mcount = 0;
  int npush  = 0;
  logic [REG_W+DATA_W-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; stall and accepted pushes follow the bench's own occupancy model.
  task automatic set_in(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2);
    logic exp_stall;
    @(negedge clk);
    bus.ex_valid = ev;  bus.ex_reg = er;  bus.ex_data = ed;
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    bus.rs1 = r1; bus.rs2 = r2;
    #1;
    exp_stall = (DEPTH - mcount) < 2;
    chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
    npush = 0;
    if (!exp_stall) begin
      if (mv && mr != 5'd0) begin sb.push_back({mr, md}); npush++; end
      if (ev && er != 5'd0) begin sb.push_back({er, ed}); npush++; end
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  task automatic tick();
    @(posedge clk);
    mcount = mcount - ((mcount > 0) ? 1 : 0) + npush;
    npush = 0;
  endtask

  // Every observed register write must be the oldest outstanding expected one.
  always @(negedge clk) begin
    if (!rst && bus.write_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, bus.reg_write}, 32'hdead);
      end else begin
        logic [REG_W+DATA_W-1:0] e;
        e = sb.pop_front();
        chk("wr_reg",  {27'd0, bus.reg_write}, {27'd0, e[DATA_W +: REG_W]});
        chk("wr_data", bus.data_write, e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_valid = 1'b0; bus.ex_reg = '0; bus.ex_data = '0;
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.rs1 = '0; bus.rs2 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write_en",   {31'd0, bus.write_en}, 32'd0);
    chk("rst_reg_write",  {27'd0, bus.reg_write}, 32'd0);
    chk("rst_data_write", bus.data_write, 32'd0);
    chk("rst_stall",      {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      idle(5'd3, 5'd0);
      chk("idle_write_en", {31'd0, bus.write_en}, 32'd0);
      chk("idle_fwd1_hit", {31'd0, bus.fwd1_hit}, 32'd0);
      tick();
    end

    // Single write
    set_in(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("single_ex_hit",  {31'd0, bus.fwd1_hit}, 32'd1);
    chk("single_ex_data", bus.fwd1_data, 32'h1234);
    tick();
    idle(5'd5, 5'd0);
    chk("single_lat_we",    {31'd0, bus.write_en}, 32'd0);
    chk("single_fifo_hit",  {31'd0, bus.fwd1_hit}, 32'd1);
    chk("single_fifo_data", bus.fwd1_data, 32'h1234);
    tick();
    idle(5'd5, 5'd0);
    chk("single_we",      {31'd0, bus.write_en}, 32'd1);
    chk("single_wb_hit",  {31'd0, bus.fwd1_hit}, 32'd1);
    chk("single_wb_data", bus.fwd1_data, 32'h1234);
    tick();
    idle(5'd5, 5'd0);
    chk("single_we_off",   {31'd0, bus.write_en}, 32'd0);
    chk("single_reg_hold", {27'd0, bus.reg_write}, 32'd5);
    chk("single_dat_hold", bus.data_write, 32'h1234);
    chk("single_no_hit",   {31'd0, bus.fwd1_hit}, 32'd0);
    tick();

    // Same-cycle ordering, same destination
    set_in(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 32'hA, 5'd7, 5'd7);
    chk("ord_in_d1", bus.fwd1_data, 32'hB);
    chk("ord_in_d2", bus.fwd2_data, 32'hB);
    tick();
    idle(5'd7, 5'd0);
    chk("ord_q2_data", bus.fwd1_data, 32'hB);
    tick();
    idle(5'd7, 5'd0);
    chk("ord_q1_data", bus.fwd1_data, 32'hB);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd7, 5'd9);
    chk("ord_wb_data",  bus.fwd1_data, 32'hB);
    chk("mem_in_hit",   {31'd0, bus.fwd2_hit}, 32'd1);
    chk("mem_in_data",  bus.fwd2_data, 32'h99);
    tick();
    idle(5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    tick();

    // R0 filter
    set_in(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("r0_hit",  {31'd0, bus.fwd1_hit}, 32'd0);
    chk("r0_data", bus.fwd1_data, 32'd0);
    tick();
    idle(5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    chk("r0_no_we", {31'd0, bus.write_en}, 32'd0);
    tick();

    // Fill to stall, inputs ignored while stalled, drain in order
    set_in(1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 32'h11, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
    chk("fill_stalled", {31'd0, bus.stall}, 32'd1);
    tick();
    idle(5'd5, 5'd4);
    chk("fill_dropped_hit", {31'd0, bus.fwd1_hit}, 32'd0);
    chk("fill_q_data",      bus.fwd2_data, 32'h44);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(5'd0, 5'd0);
      tick();
    end
    idle(5'd6, 5'd0);
    chk("fill_drained_we", {31'd0, bus.write_en}, 32'd0);
    chk("fill_no_hit6",    {31'd0, bus.fwd1_hit}, 32'd0);
    tick();

    // Async reset with entries pending
    set_in(1'b1, 5'd9, 32'h90, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd11, 32'hB0, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    bus.ex_valid = 1'b0; bus.mem_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_we",    {31'd0, bus.write_en}, 32'd0);
    chk("arst_stall", {31'd0, bus.stall}, 32'd0);
    chk("arst_reg",   {27'd0, bus.reg_write}, 32'd0);
    sb.delete();
    mcount = 0;
    npush = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(5'd10, 5'd11);
      chk("arst_after_we",  {31'd0, bus.write_en}, 32'd0);
      chk("arst_after_hit", {31'd0, bus.fwd1_hit}, 32'd0);
      tick();
    end

    idle(5'd0, 5'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
